// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Pipeline-side bundle for the hazard controller. It carries
//                the register indices and control bits sampled from
//                ID/EX/MEM/WB, and returns the forwarding selects and the
//                stall/flush enables.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_regwrite;
    logic       ex_memread;
    logic       ex_md_start;
    logic       ex_branch_taken;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite;

    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall_if;
    logic       stall_id;
    logic       stall_ex;
    logic       flush_id;
    logic       flush_ex;
    logic       flush_mem;
    logic       md_busy;

    // Pipeline side: presents stage information, consumes controls
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
        output ex_md_start, ex_branch_taken,
        output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        input  fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_ex,
        input  flush_id, flush_ex, flush_mem, md_busy
    );

    // Hazard controller side
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
        input  ex_md_start, ex_branch_taken,
        input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
        output fwd_a_sel, fwd_b_sel, stall_if, stall_id, stall_ex,
        output flush_id, flush_ex, flush_mem, md_busy
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller for the 5-stage core. Produces EX operand
//                forwarding selects, load-use (or RAW) stalls, taken-branch
//                flushes and MUL/DIV occupancy stalls.
//                Build option HAZARD_FWD_EN: when defined, operands are
//                forwarded from MEM/WB and only load-use hazards stall;
//                when undefined, selects stay 00 and any EX/MEM writer
//                matching a used ID source stalls the front end.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MD_LATENCY = 4   // cycles a MUL/DIV op occupies EX, 2..16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hazard_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // First-cycle stall happens in RUN, so the counter covers the rest
    localparam logic [3:0] c_MD_INIT = 4'(MD_LATENCY - 2);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;

    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_data_haz;
    logic       w_md_stall;
    logic       w_br_flush;
    logic       w_haz_stall;

`ifdef HAZARD_FWD_EN
    // MEM result is newer than WB, so it wins when both match
    function automatic logic [1:0] f_fwd_sel(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b10;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    logic w_unused_fwd;

    assign w_fwd_a = f_fwd_sel(bus.ex_rs1, bus.mem_regwrite, bus.mem_rd,
                               bus.wb_regwrite, bus.wb_rd);
    assign w_fwd_b = f_fwd_sel(bus.ex_rs2, bus.mem_regwrite, bus.mem_rd,
                               bus.wb_regwrite, bus.wb_rd);

    // Only a load in EX cannot be forwarded in time for the ID consumer
    assign w_data_haz = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    assign w_unused_fwd = bus.ex_regwrite;
`else
    logic w_unused_nofwd;

    assign w_fwd_a = 2'b00;
    assign w_fwd_b = 2'b00;

    // Without forwarding, any in-flight EX/MEM writer of a used source stalls;
    // WB writes the regfile before ID reads it, so it never needs a stall.
    assign w_data_haz =
        (bus.id_use_rs1 && (bus.id_rs1 != 5'd0) &&
         ((bus.ex_regwrite  && (bus.id_rs1 == bus.ex_rd)) ||
          (bus.mem_regwrite && (bus.id_rs1 == bus.mem_rd)))) ||
        (bus.id_use_rs2 && (bus.id_rs2 != 5'd0) &&
         ((bus.ex_regwrite  && (bus.id_rs2 == bus.ex_rd)) ||
          (bus.mem_regwrite && (bus.id_rs2 == bus.mem_rd))));

    assign w_unused_nofwd = ^{bus.ex_rs1, bus.ex_rs2, bus.ex_memread,
                              bus.wb_rd, bus.wb_regwrite};
`endif

    // Next-state logic and hazard classification; MD_WAIT ignores EX inputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_stall  = 1'b0;
        w_br_flush  = 1'b0;
        w_haz_stall = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    w_br_flush = 1'b1;
                end else if (bus.ex_md_start) begin
                    w_md_stall  = 1'b1;
                    w_state_nxt = MD_WAIT;
                    w_cnt_nxt   = c_MD_INIT;
                end else if (w_data_haz) begin
                    w_haz_stall = 1'b1;
                end
            end
            MD_WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_md_stall = 1'b1;
                    w_cnt_nxt  = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Output decode; reset silences every output immediately
    always_comb begin
        bus.fwd_a_sel = 2'b00;
        bus.fwd_b_sel = 2'b00;
        bus.stall_if  = 1'b0;
        bus.stall_id  = 1'b0;
        bus.stall_ex  = 1'b0;
        bus.flush_id  = 1'b0;
        bus.flush_ex  = 1'b0;
        bus.flush_mem = 1'b0;
        bus.md_busy   = 1'b0;
        if (!rst) begin
            bus.fwd_a_sel = w_fwd_a;
            bus.fwd_b_sel = w_fwd_b;
            bus.stall_if  = w_md_stall | w_haz_stall;
            bus.stall_id  = w_md_stall | w_haz_stall;
            bus.stall_ex  = w_md_stall;
            bus.flush_id  = w_br_flush;
            bus.flush_ex  = w_br_flush | w_haz_stall;
            bus.flush_mem = w_md_stall;
            bus.md_busy   = w_md_stall;
        end
    end

    // State and occupancy counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Two instances run side
//                by side (MD_LATENCY 4 and 2) on identical stimulus:
//                table vectors, hand sequences for multi-cycle cases, then
//                random traffic against an occupancy-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // Control nibble order: stall_if stall_id stall_ex flush_id flush_ex flush_mem md_busy
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_MD   = 7'b1110011;
    localparam logic [6:0] C_BR   = 7'b0001100;
    localparam logic [6:0] C_LU   = 7'b1100100;

    typedef struct packed {
        logic [4:0] id_rs1, id_rs2;
        logic       id_u1, id_u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_rw, ex_mr, ex_md, ex_br;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
    } in_t;

    typedef struct {
        string      nm;
        in_t        x;
        logic [1:0] ea;
        logic [1:0] eb;
        logic [6:0] ctl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if if0 ();
    hazard_ctrl_if if1 ();

    hazard_ctrl #(.MD_LATENCY(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    hazard_ctrl #(.MD_LATENCY(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    logic [10:0] o0, o1;
    assign o0 = {if0.fwd_a_sel, if0.fwd_b_sel, if0.stall_if, if0.stall_id, if0.stall_ex,
                 if0.flush_id, if0.flush_ex, if0.flush_mem, if0.md_busy};
    assign o1 = {if1.fwd_a_sel, if1.fwd_b_sel, if1.stall_if, if1.stall_id, if1.stall_ex,
                 if1.flush_id, if1.flush_ex, if1.flush_mem, if1.md_busy};

    int checks = 0;
    int errors = 0;

    // Reference model: remaining EX occupancy cycles per instance
    int occ [2] = '{0, 0};
    int lat [2] = '{4, 2};

    function automatic logic [1:0] fw(input logic [1:0] s);
        return FWD ? s : 2'b00;
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] rs, input in_t x);
        if (!FWD) return 2'b00;
        if (x.mem_rw && x.mem_rd != 0 && x.mem_rd == rs) return 2'b10;
        if (x.wb_rw && x.wb_rd != 0 && x.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_src_haz(input logic u, input logic [4:0] rs, input in_t x);
        if (!u || rs == 0) return 1'b0;
        if (FWD) return x.ex_mr && (x.ex_rd == rs);
        return (x.ex_rw && x.ex_rd == rs) || (x.mem_rw && x.mem_rd == rs);
    endfunction

    function automatic logic [10:0] model_out(input int k, input in_t x, input logic r);
        logic [6:0] c;
        if (r) return 11'd0;
        if (occ[k] > 1)                                c = C_MD;
        else if (occ[k] == 1)                          c = C_NONE;
        else if (x.ex_br)                              c = C_BR;
        else if (x.ex_md)                              c = C_MD;
        else if (m_src_haz(x.id_u1, x.id_rs1, x) ||
                 m_src_haz(x.id_u2, x.id_rs2, x))      c = C_LU;
        else                                           c = C_NONE;
        return {m_sel(x.ex_rs1, x), m_sel(x.ex_rs2, x), c};
    endfunction

    task automatic m_tick(input in_t x, input logic r);
        for (int k = 0; k < 2; k++) begin
            if (r)                       occ[k] = 0;
            else if (occ[k] > 0)         occ[k] = occ[k] - 1;
            else if (!x.ex_br && x.ex_md) occ[k] = lat[k] - 1;
        end
    endtask

    task automatic drive(input in_t x);
        if0.id_rs1 = x.id_rs1;  if1.id_rs1 = x.id_rs1;
        if0.id_rs2 = x.id_rs2;  if1.id_rs2 = x.id_rs2;
        if0.id_use_rs1 = x.id_u1;  if1.id_use_rs1 = x.id_u1;
        if0.id_use_rs2 = x.id_u2;  if1.id_use_rs2 = x.id_u2;
        if0.ex_rs1 = x.ex_rs1;  if1.ex_rs1 = x.ex_rs1;
        if0.ex_rs2 = x.ex_rs2;  if1.ex_rs2 = x.ex_rs2;
        if0.ex_rd = x.ex_rd;    if1.ex_rd = x.ex_rd;
        if0.ex_regwrite = x.ex_rw;  if1.ex_regwrite = x.ex_rw;
        if0.ex_memread = x.ex_mr;   if1.ex_memread = x.ex_mr;
        if0.ex_md_start = x.ex_md;  if1.ex_md_start = x.ex_md;
        if0.ex_branch_taken = x.ex_br;  if1.ex_branch_taken = x.ex_br;
        if0.mem_rd = x.mem_rd;  if1.mem_rd = x.mem_rd;
        if0.mem_regwrite = x.mem_rw;  if1.mem_regwrite = x.mem_rw;
        if0.wb_rd = x.wb_rd;    if1.wb_rd = x.wb_rd;
        if0.wb_regwrite = x.wb_rw;  if1.wb_regwrite = x.wb_rw;
    endtask

    task automatic cmp(input string nm, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b (sel_a sel_b if id ex fid fex fmem busy)",
                     nm, got, exp);
        end
    endtask

    // Hand-written expectation for both instances
    task automatic hstep(input string nm, input in_t x, input logic r,
                         input logic [10:0] e0, input logic [10:0] e1);
        drive(x);
        rst = r;
        @(negedge clk);
        cmp({nm, "/lat4"}, o0, e0);
        cmp({nm, "/lat2"}, o1, e1);
        @(posedge clk);
        m_tick(x, r);
        #1;
    endtask

    // Model-predicted expectation for both instances
    task automatic rstep(input string nm, input in_t x, input logic r);
        drive(x);
        rst = r;
        @(negedge clk);
        cmp({nm, "/lat4"}, o0, model_out(0, x, r));
        cmp({nm, "/lat2"}, o1, model_out(1, x, r));
        @(posedge clk);
        m_tick(x, r);
        #1;
    endtask

    function automatic vec_t mkv(input string nm, input in_t x, input logic [1:0] ea,
                                 input logic [1:0] eb, input logic [6:0] ctl);
        vec_t v;
        v.nm = nm; v.x = x; v.ea = ea; v.eb = eb; v.ctl = ctl;
        return v;
    endfunction

    vec_t vq[$];

    initial begin
        in_t t;
        t = '0;
        drive(t);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset forces everything low even with matching forwarding inputs
        t = '0; t.ex_rs1 = 5; t.mem_rd = 5; t.mem_rw = 1; t.ex_md = 1;
        hstep("reset_outputs", t, 1'b1, 11'd0, 11'd0);

        // ---------------- table-driven vectors (all in RUN) ----------------
        t = '0; t.ex_rs1 = 5; t.mem_rd = 5; t.mem_rw = 1; t.wb_rd = 5; t.wb_rw = 1;
        vq.push_back(mkv("fwd_mem_beats_wb", t, fw(2'b10), 2'b00, C_NONE));
        t.mem_rw = 0;
        vq.push_back(mkv("fwd_wb", t, fw(2'b01), 2'b00, C_NONE));
        t = '0; t.mem_rw = 1; t.wb_rw = 1;
        vq.push_back(mkv("fwd_x0_never", t, 2'b00, 2'b00, C_NONE));
        t = '0; t.ex_rs1 = 9; t.ex_rs2 = 9; t.mem_rd = 9; t.mem_rw = 1; t.wb_rd = 4; t.wb_rw = 1;
        vq.push_back(mkv("fwd_both_mem", t, fw(2'b10), fw(2'b10), C_NONE));
        t = '0; t.ex_mr = 1; t.ex_rw = 1; t.ex_rd = 7; t.id_rs2 = 7; t.id_u2 = 1;
        vq.push_back(mkv("load_use", t, 2'b00, 2'b00, C_LU));
        t = '0; t.ex_rs2 = 7; t.wb_rd = 7; t.wb_rw = 1;
        vq.push_back(mkv("after_lu_fwd_wb", t, 2'b00, fw(2'b01), C_NONE));
        t = '0; t.ex_mr = 1; t.ex_rw = 1; t.ex_rd = 7; t.id_rs2 = 7; t.id_u2 = 0;
        vq.push_back(mkv("lu_src_unused", t, 2'b00, 2'b00, C_NONE));
        t = '0; t.ex_mr = 1; t.ex_rw = 1; t.id_u1 = 1; t.id_u2 = 1;
        vq.push_back(mkv("lu_rd_zero", t, 2'b00, 2'b00, C_NONE));
        t = '0; t.ex_mr = 1; t.ex_rw = 1; t.ex_rd = 7; t.id_rs2 = 7; t.id_u2 = 1; t.ex_br = 1;
        vq.push_back(mkv("branch_beats_lu", t, 2'b00, 2'b00, C_BR));
        t = '0; t.ex_md = 1; t.ex_br = 1;
        vq.push_back(mkv("branch_beats_md", t, 2'b00, 2'b00, C_BR));
        t = '0; t.id_rs1 = 3; t.id_u1 = 1; t.mem_rd = 3; t.mem_rw = 1;
        vq.push_back(mkv("mem_writer_raw", t, 2'b00, 2'b00, FWD ? C_NONE : C_LU));
        t = '0; t.id_rs1 = 6; t.id_u1 = 1; t.ex_rd = 6; t.ex_rw = 1;
        vq.push_back(mkv("ex_alu_writer_raw", t, 2'b00, 2'b00, FWD ? C_NONE : C_LU));
        t = '0; t.id_rs1 = 4; t.id_u1 = 1; t.wb_rd = 4; t.wb_rw = 1;
        vq.push_back(mkv("wb_writer_no_stall", t, 2'b00, 2'b00, C_NONE));

        for (int i = 0; i < vq.size(); i++)
            hstep(vq[i].nm, vq[i].x, 1'b0, {vq[i].ea, vq[i].eb, vq[i].ctl},
                  {vq[i].ea, vq[i].eb, vq[i].ctl});

        // ---- MD held continuously with a load-use pending: back-to-back ops ----
        t = '0; t.ex_md = 1; t.ex_mr = 1; t.ex_rw = 1; t.ex_rd = 7; t.id_rs2 = 7; t.id_u2 = 1;
        for (int i = 0; i < 8; i++)
            hstep($sformatf("md_hold_c%0d", i), t, 1'b0,
                  {4'b0000, (i % 4 != 3) ? C_MD : C_NONE},
                  {4'b0000, (i % 2 == 0) ? C_MD : C_NONE});
        t.ex_md = 0;
        hstep("md_done_run_lu", t, 1'b0, {4'b0000, C_LU}, {4'b0000, C_LU});

        // ---- reset in the second MD_WAIT cycle of the latency-4 unit ----
        t = '0; t.ex_md = 1;
        hstep("rst_md_start", t, 1'b0, {4'b0000, C_MD}, {4'b0000, C_MD});
        t.ex_md = 0;
        hstep("rst_md_wait1", t, 1'b0, {4'b0000, C_MD}, {4'b0000, C_NONE});
        t.ex_rs1 = 5; t.mem_rd = 5; t.mem_rw = 1;
        hstep("rst_mid_md", t, 1'b1, 11'd0, 11'd0);
        hstep("rst_release", t, 1'b0, {fw(2'b10), 2'b00, C_NONE}, {fw(2'b10), 2'b00, C_NONE});

        // ---- branch suppresses MD start ----
        t = '0; t.ex_md = 1; t.ex_br = 1;
        hstep("br_md_flush", t, 1'b0, {4'b0000, C_BR}, {4'b0000, C_BR});
        t = '0;
        hstep("br_md_not_started", t, 1'b0, {4'b0000, C_NONE}, {4'b0000, C_NONE});

        // ---------------- random traffic against the model ----------------
        t = '0;
        rstep("rand_sync", t, 1'b1);
        for (int i = 0; i < 600; i++) begin
            logic r;
            t.id_rs1 = 5'($urandom_range(0, 3));
            t.id_rs2 = 5'($urandom_range(0, 3));
            t.id_u1  = 1'($urandom_range(0, 1));
            t.id_u2  = 1'($urandom_range(0, 1));
            t.ex_rs1 = 5'($urandom_range(0, 3));
            t.ex_rs2 = 5'($urandom_range(0, 3));
            t.ex_rd  = 5'($urandom_range(0, 3));
            t.ex_rw  = 1'($urandom_range(0, 1));
            t.ex_mr  = 1'($urandom_range(0, 1));
            t.ex_md  = ($urandom_range(0, 5) == 0);
            t.ex_br  = ($urandom_range(0, 7) == 0);
            t.mem_rd = 5'($urandom_range(0, 3));
            t.mem_rw = 1'($urandom_range(0, 1));
            t.wb_rd  = 5'($urandom_range(0, 3));
            t.wb_rw  = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 39) == 0);
            rstep($sformatf("rand_c%0d", i), t, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. Drives the EX-stage operand-forwarding mux selects, generates load-use stalls, branch flushes and multi-cycle MUL/DIV occupancy stalls. Sits beside the pipeline registers: it reads register indices and control bits from ID/EX/MEM/WB and returns mux selects plus stall/flush enables for the IF/ID, ID/EX and EX/MEM registers.

## Interface
Parameters:
- MD_LATENCY, 4, total cycles a MUL/DIV op occupies EX including its first cycle; legal range 2..16

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads that source
- ex_rs1, ex_rs2  in  5  source registers of the instruction in EX
- ex_rd  in  5  EX destination; ex_regwrite in 1; ex_memread in 1 (EX holds a load)
- ex_md_start  in  1  EX holds a MUL/DIV op
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_rd  in  5; mem_regwrite  in  1
- wb_rd  in  5; wb_regwrite  in  1
- fwd_a_sel, fwd_b_sel  out  2  EX operand mux selects: 00 regfile, 01 WB result, 10 MEM ALU result; 11 never driven
- stall_if, stall_id  out  1  hold PC and IF/ID register
- stall_ex  out  1  hold ID/EX register
- flush_id  out  1  bubble into IF/ID
- flush_ex  out  1  bubble into ID/EX
- flush_mem  out  1  bubble into EX/MEM
- md_busy  out  1  MUL/DIV occupancy in progress

## Operation
- Forwarding (per operand, shown for A): 10 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1; else 01 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1; else 00. MEM beats WB.
- Load-use hazard lu: ex_memread & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Response: stall_if=stall_id=1, flush_ex=1 for that cycle. Dependent then forwards from WB (01).
- FSM states RUN, MD_WAIT; 4-bit down-counter cnt.
  - RUN & ex_md_start & !ex_branch_taken: md stall this cycle; next state MD_WAIT, cnt<=MD_LATENCY-2.
  - MD_WAIT & cnt!=0: md stall; cnt<=cnt-1.
  - MD_WAIT & cnt==0: no md stall; EX advances; next state RUN.
  - md stall: stall_if=stall_id=stall_ex=1, flush_mem=1, md_busy=1.
- In MD_WAIT, ex_md_start, ex_branch_taken and lu are ignored (EX is held).
- Priority in RUN: ex_branch_taken > md stall > lu. Branch: flush_id=flush_ex=1, all stalls 0, MD op not started.
- MD_LATENCY=2 yields exactly one stalled cycle.

## Timing
- Selects, stalls, flushes combinational from inputs and registered state; state/cnt update on clk rising edge.
- Reset (rst high at edge): state RUN, cnt 0. While rst high all outputs forced 0 combinationally, including mid-MD_WAIT; abort is silent.
- MUL/DIV: EX occupied exactly MD_LATENCY cycles; stalls asserted MD_LATENCY-1 consecutive cycles starting with the ex_md_start cycle.
- Load-use: exactly one stall cycle per hazard.
- Back-to-back MD ops: RUN cycle after release sees new ex_md_start and restarts immediately.

## Configuration
- HAZARD_FWD_EN defined: forwarding as above.
- Undefined: fwd_a_sel=fwd_b_sel=00 always; RAW stall replaces lu: stall_if=stall_id=flush_ex=1 while any used ID source !=0 matches ex_rd (ex_regwrite) or mem_rd (mem_regwrite). WB matches need no stall (regfile writes before read). Same priority/FSM rules apply.

## Test plan
- EX add x5; MEM writes x5 (mem_regwrite) and WB writes x5, ex_rs1=5 -> fwd_a_sel=10; drop mem_regwrite -> 01; ex_rs1=0 -> 00.
- ex_memread, ex_rd=7, id_rs2=7, id_use_rs2=1 -> one cycle stall_if=stall_id=flush_ex=1; next cycle, wb_rd=7, ex_rs2=7 -> fwd_b_sel=01.
- MD_LATENCY=4, ex_md_start held -> stall_ex/flush_mem/md_busy high 3 cycles, low in 4th; state back to RUN.
- ex_branch_taken with simultaneous lu -> flush_id=flush_ex=1, stalls 0; branch with ex_md_start -> md_busy stays 0.
- rst asserted in 2nd MD_WAIT cycle -> all outputs 0 during rst; after release RUN, no stall absent new ex_md_start.
- HAZARD_FWD_EN undefined, mem_rd=3 writing, id_rs1=3 used -> stall_if=flush_ex=1 until MEM writer moves on; selects 00.
